darkflash_arbiter: RTL
======================

# darkflash_arbiter

Two-requester read arbiter and access sequencer for the on-chip flash/boot memory. Shares the single-ported flash between the instruction-fetch port and the data-load port. Serialises accesses, drives the flash enable/read/address/byte-enable lines for a programmable number of wait cycles, captures the read word and returns it to the winner with a one-cycle acknowledge. Sits between the core's bus decode and the flash memory instance.

## Interface
- WAIT_CYCLES, 1, flash access time in cycles (M_EN held high); legal 1..15
- FAIR, 1, 1 = round-robin on ties, 0 = fixed priority (data port wins)
- XCLK  in  1  system clock, rising edge
- XRES  in  1  reset, asynchronous, active-high
- I_REQ  in  1  instruction-fetch request, held until I_ACK
- I_ADDR  in  32  fetch byte address, stable while I_REQ high
- I_ACK  out  1  one-cycle acknowledge; I_DATA valid this cycle
- I_DATA  out  32  fetch read word
- D_REQ  in  1  data-load request, held until D_ACK
- D_ADDR  in  32  load byte address, stable while D_REQ high
- D_BE  in  4  load byte enables
- D_ACK  out  1  one-cycle acknowledge; D_DATA valid this cycle
- D_DATA  out  32  load read word
- M_EN  out  1  flash enable
- M_RE  out  1  flash read strobe, equal to M_EN
- M_ADDR  out  32  flash byte address (flash indexes by [31:2])
- M_BE  out  4  flash byte enables
- M_DATA  in  32  flash read data, valid in last M_EN cycle

## Operation
- FSM states: ST_IDLE, ST_ACCESS, ST_RESP.
- ST_IDLE: if no REQ, stay. If one REQ, grant it. If both: FAIR=1 grants the port not granted last; FAIR=0 grants D. On grant, latch address into M_ADDR, load M_BE with D_BE for D or 4'hF for I, set M_EN=M_RE=1, load wait counter with WAIT_CYCLES-1, go ST_ACCESS, update last_grant.
- ST_ACCESS: M_EN/M_RE/M_ADDR/M_BE held. Counter decrements each cycle; at count 0, capture M_DATA into the granted port's DATA register, drop M_EN/M_RE, pulse the granted ACK, go ST_RESP.
- ST_RESP: granted ACK=1 for exactly this cycle; other port's ACK=0 and DATA unchanged; return to ST_IDLE unconditionally. The just-served REQ is not sampled here.
- Requests are not cancellable: if REQ drops mid-access, the access completes and ACK still pulses.
- The counter is 4 bits and never underflows; it is reloaded only on grant.

## Timing
- Reset values: state ST_IDLE, I_ACK=D_ACK=0, I_DATA=D_DATA=0, M_EN=M_RE=0, M_ADDR=0, M_BE=0, last_grant=D (first tie goes to I when FAIR=1), counter=0.
- XRES mid-access forces reset values immediately; no ACK is issued for the aborted access.
- Latency: REQ seen in ST_IDLE at cycle 0 -> M_EN high cycles 1..WAIT_CYCLES -> ACK at cycle WAIT_CYCLES+1.
- Throughput: one access per WAIT_CYCLES+2 cycles. A requester holding REQ after ACK is re-granted no earlier than the ST_IDLE cycle following ST_RESP.
- Starvation bound (FAIR=1, both requesting continuously): each port waits at most one other access.
- All outputs are registered. There is no combinational path from REQ to ACK or to M_*.

## Structure
- darkflash_pkg holds:
  - typedef enum state_t {ST_IDLE, ST_ACCESS, ST_RESP}
  - typedef enum grant_t {GNT_I, GNT_D}
  - localparam WAIT_W = 4
- Sub-module darkflash_rr: 2-way round-robin/fixed-priority picker. Inputs: the two REQs, last_grant, FAIR. Output: grant_t plus a valid flag. Purely combinational.
- The FSM, counter and data registers live in darkflash_arbiter.

## Test plan
- Single I fetch, WAIT_CYCLES=1, I_ADDR=0x10, M_DATA=0xDEADBEEF -> M_EN high cycle 1 with M_ADDR=0x10, M_BE=4'hF; I_ACK and I_DATA=0xDEADBEEF at cycle 2; D_ACK stays 0.
- Simultaneous I and D from reset, FAIR=1 -> I served first (ACK cycle 2), then D (M_EN cycle 4 with M_BE=D_BE=4'b0011, D_ACK cycle 5); continuous requests alternate I,D,I,D.
- FAIR=0, both held continuously for 4 accesses -> D served every time, I never acknowledged.
- WAIT_CYCLES=3, D_ADDR=0x204 -> M_EN high exactly cycles 1..3; D_ACK at cycle 4 with the M_DATA sampled in cycle 3.
- XRES asserted during ST_ACCESS -> M_EN, M_RE and both ACKs at 0 immediately; no ACK afterwards; a new request after release is served with normal latency.
- D_REQ dropped one cycle after grant -> access completes; D_ACK still pulses at cycle WAIT_CYCLES+1; FSM back in ST_IDLE the next cycle.

Source files
------------

// File: rtl/darkflash_pkg.sv
// Shared types for the flash read arbiter: FSM states, grant encoding and counter width.
package darkflash_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } grant_t;

endpackage

// File: rtl/darkflash_rr.sv
// Two-way request picker: round-robin on ties when fair_i is set, otherwise the data port wins.
module darkflash_rr
  import darkflash_pkg::*;
(
  input  logic   i_req_i,
  input  logic   d_req_i,
  input  grant_t last_grant_i,
  input  logic   fair_i,
  output grant_t grant_o,
  output logic   valid_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant_o = GNT_D;
    valid_o = i_req_i | d_req_i;
    if (i_req_i && d_req_i) begin
      if (fair_i && (last_grant_i == GNT_D)) grant_o = GNT_I;
    end else if (i_req_i) begin
      grant_o = GNT_I;
    end
  end

endmodule

// File: rtl/darkflash_arbiter.sv
// Arbitrates instruction-fetch and data-load reads onto the single-ported flash, holds the
// flash strobes for WAIT_CYCLES and returns the captured word with a one-cycle acknowledge.
module darkflash_arbiter
  import darkflash_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter bit          FAIR        = 1'b1
) (
  input  logic        XCLK,
  input  logic        XRES,
  input  logic        I_REQ,
  input  logic [31:0] I_ADDR,
  output logic        I_ACK,
  output logic [31:0] I_DATA,
  input  logic        D_REQ,
  input  logic [31:0] D_ADDR,
  input  logic [3:0]  D_BE,
  output logic        D_ACK,
  output logic [31:0] D_DATA,
  output logic        M_EN,
  output logic        M_RE,
  output logic [31:0] M_ADDR,
  output logic [3:0]  M_BE,
  input  logic [31:0] M_DATA
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] CNT_ONE   = WAIT_W'(1);

  state_t            state_q, state_d;
  grant_t            last_q, last_d;
  grant_t            gnt_q, gnt_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [31:0]       i_data_q, i_data_d;
  logic [31:0]       d_data_q, d_data_d;
  logic              m_en_q, m_en_d;
  logic [31:0]       m_addr_q, m_addr_d;
  logic [3:0]        m_be_q, m_be_d;

  grant_t            pick;
  logic              pick_valid;

  darkflash_rr u_rr (
    .i_req_i      (I_REQ),
    .d_req_i      (D_REQ),
    .last_grant_i (last_q),
    .fair_i       (FAIR),
    .grant_o      (pick),
    .valid_o      (pick_valid)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    i_ack_d  = i_ack_q;
    d_ack_d  = d_ack_q;
    i_data_d = i_data_q;
    d_data_d = d_data_q;
    m_en_d   = m_en_q;
    m_addr_d = m_addr_q;
    m_be_d   = m_be_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick;
          last_d  = pick;
          cnt_d   = WAIT_LOAD;
          m_en_d  = 1'b1;
          state_d = ST_ACCESS;
          if (pick == GNT_D) begin
            m_addr_d = D_ADDR;
            m_be_d   = D_BE;
          end else begin
            m_addr_d = I_ADDR;
            m_be_d   = 4'hF;
          end
        end
      end
      ST_ACCESS: begin
        // Flash data is only guaranteed in the last enabled cycle, i.e. when the count hits 0.
        if (cnt_q == '0) begin
          m_en_d  = 1'b0;
          state_d = ST_RESP;
          if (gnt_q == GNT_D) begin
            d_data_d = M_DATA;
            d_ack_d  = 1'b1;
          end else begin
            i_data_d = M_DATA;
            i_ack_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RESP: begin
        i_ack_d = 1'b0;
        d_ack_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge XCLK or posedge XRES) begin
    if (XRES) begin
      state_q  <= ST_IDLE;
      last_q   <= GNT_D;
      gnt_q    <= GNT_D;
      cnt_q    <= '0;
      i_ack_q  <= 1'b0;
      d_ack_q  <= 1'b0;
      i_data_q <= '0;
      d_data_q <= '0;
      m_en_q   <= 1'b0;
      m_addr_q <= '0;
      m_be_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      i_ack_q  <= i_ack_d;
      d_ack_q  <= d_ack_d;
      i_data_q <= i_data_d;
      d_data_q <= d_data_d;
      m_en_q   <= m_en_d;
      m_addr_q <= m_addr_d;
      m_be_q   <= m_be_d;
    end
  end

  assign I_ACK  = i_ack_q;
  assign I_DATA = i_data_q;
  assign D_ACK  = d_ack_q;
  assign D_DATA = d_data_q;
  assign M_EN   = m_en_q;
  assign M_RE   = m_en_q;
  assign M_ADDR = m_addr_q;
  assign M_BE   = m_be_q;

endmodule
